// File: rtl/cache_trace_checker.sv
// -----------------------------------------------------------------------------
// cache_trace_checker
//   Trace-driven stimulus and scoreboard engine for one cache port. A trace of
//   loads and stores is written into a local RAM while idle. A run first fills
//   the golden memory with golden[i] = i, then replays the trace into the cache
//   request port. Each issued op travels down a PIPE_DEPTH-stage pipe that
//   freezes on stall. At the last stage, loads are compared against the golden
//   memory and stores update it byte-masked. The first error is latched.
//
// Optional feature: define CHECKER_TIMEOUT_EN to add a stall watchdog that
//   fails the run after TIMEOUT_CYCLES consecutive stalled cycles in RUN/DRAIN.
//
// Ports
//   clk, rstn        clock; synchronous active-low reset
//   start            begin a run (accepted in IDLE/DONE/FAIL)
//   tr_we            trace write strobe (accepted in IDLE only)
//   tr_waddr         trace write index
//   tr_addr/type/wdata  trace entry fields; type = {store,load,unsigned,log2 size}
//   tr_count         number of entries to replay, captured on start
//   req_addr/type/wdata request to the cache; type 0 means bubble
//   stall            cache miss; freezes issue and the whole pipe
//   rsp_rdata        load data for the op in the last stage
//   busy             high in INIT/RUN/DRAIN
//   pass, fail       sticky run result
//   err_code         0 none, 1 data mismatch, 2 misaligned, 3 timeout
//   err_index/exp/act trace index, expected and actual data of the first error
// -----------------------------------------------------------------------------
module cache_trace_checker #(
   parameter int PIPE_DEPTH = 2,
   parameter int WORDS      = 1024,
   parameter int TRACE_LEN  = 256
`ifdef CHECKER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         start,
   input  logic                         tr_we,
   input  logic [$clog2(TRACE_LEN)-1:0] tr_waddr,
   input  logic [31:0]                  tr_addr,
   input  logic [4:0]                   tr_type,
   input  logic [31:0]                  tr_wdata,
   input  logic [$clog2(TRACE_LEN):0]   tr_count,
   output logic [31:0]                  req_addr,
   output logic [4:0]                   req_type,
   output logic [31:0]                  req_wdata,
   input  logic                         stall,
   input  logic [31:0]                  rsp_rdata,
   output logic                         busy,
   output logic                         pass,
   output logic                         fail,
   output logic [1:0]                   err_code,
   output logic [$clog2(TRACE_LEN)-1:0] err_index,
   output logic [31:0]                  err_exp,
   output logic [31:0]                  err_act
);

   localparam int IW = $clog2(TRACE_LEN);
   localparam int GW = $clog2(WORDS);
   localparam int AW = GW + 2;               // address bits that reach golden memory
   localparam int DW = $clog2(PIPE_DEPTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE, S_FAIL} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [4:0]  typ;
      logic [31:0] wdata;
   } trace_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [4:0]    typ;
      logic [31:0]   wdata;
      logic [IW-1:0] idx;
   } stage_t;

   // NOTE: the trace RAM and golden memory have no reset; they are plain
   // storage, and the golden memory is fully rewritten in INIT on every run.
   trace_t      tr_ram [TRACE_LEN];
   logic [31:0] golden [WORDS];

   state_t        state, state_nx;
   logic [IW:0]   count, issue_cnt, issue_nx;
   logic [GW-1:0] init_cnt;
   logic [DW-1:0] drain_cnt;
   stage_t        pipe [PIPE_DEPTH];
   stage_t        last, issue_stage;
   trace_t        cur;

   logic          start_ok, run_any, advance, issue_valid;
   logic          is_st, is_ld, misal, err_now, store_we, timeout_hit;
   logic [1:0]    off, size;
   logic [GW-1:0] gidx;
   logic [31:0]   gword, shifted, exp_data, wshift, merged;
   logic [3:0]    wstrb;

   assign start_ok    = start && (state == S_IDLE || state == S_DONE || state == S_FAIL);
   assign run_any     = (state == S_RUN) || (state == S_DRAIN);
   assign advance     = run_any && !stall;
   assign issue_valid = (state == S_RUN) && (issue_cnt < count);
   assign issue_nx    = issue_cnt + (IW+1)'(1);
   assign cur         = tr_ram[issue_cnt[IW-1:0]];
   assign last        = pipe[PIPE_DEPTH-1];
   assign busy        = (state == S_INIT) || run_any;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin : issue_logic
      req_addr    = '0;
      req_type    = '0;
      req_wdata   = '0;
      issue_stage = '0;
      if (issue_valid) begin
         req_addr          = cur.addr;
         req_type          = cur.typ;
         req_wdata         = cur.wdata;
         issue_stage.addr  = cur.addr[AW-1:0];
         issue_stage.typ   = cur.typ;
         issue_stage.wdata = cur.wdata;
         issue_stage.idx   = issue_cnt[IW-1:0];
      end
   end

   // Last-stage check: expected load data and byte-merged store data.
   always_comb begin : check_logic
      // NOTE: combinational blocks use blocking '=' so later lines see the
      // values just computed; clocked blocks use '<=' only.
      is_st   = last.typ[4];                  // store wins when both bits set
      is_ld   = last.typ[3] && !last.typ[4];
      size    = last.typ[1:0];
      off     = last.addr[1:0];
      gidx    = last.addr[AW-1:2];            // higher address bits wrap
      gword   = golden[gidx];
      shifted = gword >> {off, 3'b000};
      misal   = (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);

      exp_data = shifted;
      case (size)
         2'd0:    exp_data = {{24{shifted[7]  && !last.typ[2]}}, shifted[7:0]};
         2'd1:    exp_data = {{16{shifted[15] && !last.typ[2]}}, shifted[15:0]};
         default: exp_data = shifted;
      endcase

      case (size)
         2'd0:    wstrb = 4'b0001;
         2'd1:    wstrb = 4'b0011;
         default: wstrb = 4'b1111;
      endcase
      wstrb  = wstrb << off;
      wshift = last.wdata << {off, 3'b000};
      merged = gword;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) merged[8*b +: 8] = wshift[8*b +: 8];
      end

      err_now  = advance && (is_st || is_ld) && (misal || (is_ld && rsp_rdata != exp_data));
      store_we = advance && is_st && !misal;
   end

`ifdef CHECKER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] stall_cnt;

   // Counts consecutive stalled cycles; any non-stalled cycle or leaving
   // RUN/DRAIN restarts it.
   always_ff @(posedge clk) begin : watchdog
      if (!rstn || !run_any || !stall) stall_cnt <= '0;
      else                             stall_cnt <= stall_cnt + TW'(1);
   end

   assign timeout_hit = run_any && stall && (stall_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin : state_reg
      if (!rstn) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin : next_state
      state_nx = state;
      case (state)
         S_IDLE: if (start) state_nx = S_INIT;
         S_INIT: if (init_cnt == GW'(WORDS - 1)) state_nx = S_RUN;
         S_RUN: begin
            if (err_now || timeout_hit)                                      state_nx = S_FAIL;
            else if (!stall && (!issue_valid || issue_nx == count))          state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (err_now || timeout_hit)                                      state_nx = S_FAIL;
            else if (!stall && drain_cnt == DW'(PIPE_DEPTH - 1))             state_nx = S_DONE;
         end
         S_DONE, S_FAIL: if (start) state_nx = S_INIT;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin : datapath
      if (!rstn || start_ok) begin
         count     <= rstn ? tr_count : '0;
         issue_cnt <= '0;
         init_cnt  <= '0;
         drain_cnt <= '0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         err_code  <= '0;
         err_index <= '0;
         err_exp   <= '0;
         err_act   <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
      end else begin
         if (state == S_INIT)                  init_cnt  <= init_cnt + GW'(1);
         if (advance && issue_valid)           issue_cnt <= issue_nx;
         if (advance && state == S_DRAIN)      drain_cnt <= drain_cnt + DW'(1);
         // The pipe holds still on the error cycle so it stays frozen in FAIL.
         if (advance && !err_now) begin
            pipe[0] <= issue_stage;
            for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
         end
         if (state == S_DRAIN && state_nx == S_DONE) pass <= 1'b1;
         if ((err_now || timeout_hit) && !fail) begin
            fail      <= 1'b1;
            err_code  <= timeout_hit ? 2'd3 : (misal ? 2'd2 : 2'd1);
            err_index <= last.idx;
            err_exp   <= exp_data;
            err_act   <= rsp_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin : golden_write
      if (state == S_INIT) golden[init_cnt] <= 32'(init_cnt);
      else if (store_we)   golden[gidx]     <= merged;
   end

   always_ff @(posedge clk) begin : trace_write
      if (tr_we && state == S_IDLE)
         tr_ram[tr_waddr] <= '{addr: tr_addr, typ: tr_type, wdata: tr_wdata};
   end

endmodule
